// File: rtl/enemy_fire_arbiter.sv
// enemy_fire_arbiter: round-robin fire arbiter that hands the lowest free projectile slot to one ship per grant, then cools down.
// Define EFIRE_SHOTCNT_EN to add the saturating ShotCount output.
module enemy_fire_arbiter #(
    parameter int NM = 16,
    parameter int NPE = 4,
    parameter int COOLDOWN = 8
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic [NM-1:0]         FireReq,
    input  logic [NM-1:0]         ShipAlive,
    input  logic [NPE-1:0]        EProjEn,
    output logic [NPE-1:0]        EProjActvt,
    output logic [NM-1:0]         FireAck,
    output logic [$clog2(NM)-1:0] ShooterIdx,
    output logic                  Busy
`ifdef EFIRE_SHOTCNT_EN
    ,output logic [15:0]          ShotCount
`endif
);
    localparam int IW = $clog2(NM);
    localparam int SW = NPE > 1 ? $clog2(NPE) : 1;
    localparam int CW = $clog2(COOLDOWN + 2);
    localparam logic [1:0] S_IDLE = 2'd0, S_GRANT = 2'd1, S_COOL = 2'd2;
    logic [1:0]     state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d, idx_q, idx_d, win, scan;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NPE-1:0] actvt_q, actvt_d;
    logic [NM-1:0]  ack_q, ack_d, v;
    logic [SW-1:0]  slot;
    logic           grant;
    always_comb begin
        v = FireReq & ShipAlive;
        win = ptr_q;
        scan = ptr_q;
        // scan downward so the request closest to ptr is the last one written
        for (int k = NM - 1; k >= 0; k--) begin
            scan = IW'((int'(ptr_q) + k) % NM);
            if (v[scan]) win = scan;
        end
        slot = '0;
        for (int i = NPE - 1; i >= 0; i--) begin
            if (!EProjEn[i]) slot = SW'(i);
        end
        grant = state_q == S_IDLE && |v && !(&EProjEn);
        actvt_d = grant ? NPE'(1) << slot : '0;
        ack_d = grant ? NM'(1) << win : '0;
        idx_d = grant ? win : idx_q;
        ptr_d = grant ? (win == IW'(NM - 1) ? '0 : win + IW'(1)) : ptr_q;
        cnt_d = state_q == S_GRANT ? CW'(COOLDOWN > 0 ? COOLDOWN - 1 : 0) :
                (state_q == S_COOL && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        state_d = grant ? S_GRANT :
                  state_q == S_GRANT ? (COOLDOWN == 0 ? S_IDLE : S_COOL) :
                  state_q == S_COOL ? (cnt_q == '0 ? S_IDLE : S_COOL) : S_IDLE;
    end
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            actvt_q <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            actvt_q <= actvt_d;
            ack_q   <= ack_d;
        end
    end
    assign EProjActvt = actvt_q;
    assign FireAck    = ack_q;
    assign ShooterIdx = idx_q;
    assign Busy       = state_q != S_IDLE;
`ifdef EFIRE_SHOTCNT_EN
    logic [15:0] shot_q, shot_d;
    always_comb begin
        shot_d = (grant && shot_q != 16'hFFFF) ? shot_q + 16'd1 : shot_q;
    end
    always_ff @(posedge frame_clk) begin
        shot_q <= Reset ? 16'd0 : shot_d;
    end
    assign ShotCount = shot_q;
`endif
endmodule

// File: tb/tb_enemy_fire_arbiter.sv
// tb_enemy_fire_arbiter: scoreboard bench; a frame-level reference model predicts grants, a monitor checks them.
module tb_enemy_fire_arbiter;
    localparam int NM = 16;
    localparam int NPE = 4;
    localparam int C = 3;
    logic        frame_clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] FireReq = '0;
    logic [15:0] ShipAlive = '0;
    logic [3:0]  EProjEn = '0;
    logic [3:0]  EProjActvt;
    logic [15:0] FireAck;
    logic [3:0]  ShooterIdx;
    logic        Busy;
`ifdef EFIRE_SHOTCNT_EN
    logic [15:0] ShotCount;
`endif

    enemy_fire_arbiter #(.NM(NM), .NPE(NPE), .COOLDOWN(C)) dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .FireReq(FireReq),
        .ShipAlive(ShipAlive),
        .EProjEn(EProjEn),
        .EProjActvt(EProjActvt),
        .FireAck(FireAck),
        .ShooterIdx(ShooterIdx),
        .Busy(Busy)
`ifdef EFIRE_SHOTCNT_EN
        ,.ShotCount(ShotCount)
`endif
    );

    initial forever #5 frame_clk = ~frame_clk;

    typedef struct {
        int          frame;
        logic [3:0]  actvt;
        logic [15:0] ack;
        logic [3:0]  idx;
    } exp_t;
    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    int m_ptr = 0;
    int next_ok = 0;
    int busy_end = -1;
    int last_grant = -100;
    int m_shot = 0;
    logic [3:0] m_idx = '0;

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (frame %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference model: one call per clock edge, using the inputs that edge will sample.
    task automatic model_step();
        int w;
        int s;
        logic [15:0] v;
        w = -1;
        s = -1;
        v = FireReq & ShipAlive;
        edge_n++;
        if (Reset) begin
            m_ptr = 0;
            m_idx = '0;
            m_shot = 0;
            busy_end = -1;
            next_ok = edge_n + 1;
        end else if (edge_n >= next_ok) begin
            for (int k = 0; k < NM; k++) begin
                if (w < 0 && v[(m_ptr + k) % NM]) w = (m_ptr + k) % NM;
            end
            for (int i = 0; i < NPE; i++) begin
                if (s < 0 && !EProjEn[i]) s = i;
            end
            if (w >= 0 && s >= 0) begin
                q.push_back('{edge_n, 4'(1 << s), 16'(1 << w), 4'(w)});
                m_idx = 4'(w);
                m_ptr = (w + 1) % NM;
                last_grant = edge_n;
                busy_end = edge_n + C;
                next_ok = edge_n + C + 2;
                if (m_shot < 65535) m_shot++;
            end
        end
    endtask

    task automatic drive(bit r, logic [15:0] req, logic [15:0] alive, logic [3:0] en, int n);
        repeat (n) begin
            @(negedge frame_clk);
            Reset = r;
            FireReq = req;
            ShipAlive = alive;
            EProjEn = en;
            model_step();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (EProjActvt != '0 || FireAck != '0) begin
                if (q.size() == 0) begin
                    check("spurious_pulse", int'({EProjActvt, FireAck}), 0);
                end else begin
                    e = q.pop_front();
                    check("grant_frame", edge_n, e.frame);
                    check("eproj_actvt", int'(EProjActvt), int'(e.actvt));
                    check("fire_ack", int'(FireAck), int'(e.ack));
                end
            end else if (q.size() != 0 && q[0].frame <= edge_n) begin
                e = q.pop_front();
                check("missed_grant", int'(FireAck), int'(e.ack));
            end
            check("busy", int'(Busy), int'(edge_n <= busy_end));
            check("shooter_idx", int'(ShooterIdx), int'(m_idx));
`ifdef EFIRE_SHOTCNT_EN
            check("shot_count", int'(ShotCount), m_shot);
`endif
        end
    end

    initial begin
        drive(1, '0, '0, '0, 3);
        // slot allocation around busy slots
        drive(0, 16'h0008, '1, 4'b0101, 2);
        drive(0, '0, '1, '0, 5);
        // full pool, then one slot frees up
        drive(0, 16'h0004, '1, 4'b1111, 5);
        drive(0, 16'h0004, '1, 4'b0111, 1);
        drive(0, '0, '1, '0, 5);
        // dead ship masked
        drive(0, 16'h0030, 16'h0020, '0, 12);
        drive(0, '0, '1, '0, 5);
        // fairness between the two ends of the vector
        drive(0, 16'h8001, 16'h8001, '0, 20);
        drive(0, '0, '1, '0, 5);
        // continuous single requester exercises cooldown spacing
        drive(0, 16'h0002, '1, '0, 22);
        for (int i = 0; i < 10 && last_grant != edge_n; i++) drive(0, 16'h0002, '1, '0, 1);
        // reset while cooling, then pointer must restart at 0
        drive(0, '0, '1, '0, 2);
        drive(1, '0, '1, '0, 1);
        drive(0, 16'h0020, '1, '0, 1);
        drive(0, '0, '1, '0, 5);
        drive(1, '0, '1, '0, 1);
        drive(0, 16'h8002, '1, '0, 1);
        drive(0, '0, '1, '0, 5);
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) == 0, 16'($urandom), 16'($urandom) | 16'h0F0F,
                  4'($urandom_range(0, 15)), 1);
        end
        drive(0, '0, '1, '0, 8);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/enemy_fire_arbiter.md
# enemy_fire_arbiter

Frame-rate arbiter that shares the pool of enemy projectile slots among the enemy ships requesting to fire. Each frame it picks one requesting, alive ship by round-robin and assigns it the lowest-indexed free projectile slot. It then enforces a global cooldown before the next grant. It sits between the per-ship fire logic (requests) and the enemy projectile bank (`EProjEn` status in, one-hot `EProjActvt` launch pulse out).

## Interface
- `NM`, default 16: number of enemy ships (requesters).
- `NPE`, default 4: number of enemy projectile slots.
- `COOLDOWN`, default 8: frames spent in COOL after a grant; 0 is legal.
- `Reset`  in  1: synchronous, active-high reset.
- `frame_clk`  in  1: clock; one edge per video frame.
- `FireReq`  in  NM: per-ship fire request, level, held by the requester until acked.
- `ShipAlive`  in  NM: per-ship alive mask; dead ships are ignored.
- `EProjEn`  in  NPE: 1 means the projectile slot is in flight (busy).
- `EProjActvt`  out  NPE: one-hot launch pulse for the chosen slot; one frame wide.
- `FireAck`  out  NM: one-hot grant pulse to the winning ship; coincident with `EProjActvt`.
- `ShooterIdx`  out  $clog2(NM): index of the last winner; holds until the next grant.
- `Busy`  out  1: high in GRANT and COOL.

## Operation
- Valid request vector: `V = FireReq & ShipAlive`.
- Free slots: `F = ~EProjEn`.
- Round-robin pointer `ptr`, width $clog2(NM):
  - The winner is the first set bit of `V` scanning from `ptr` upward, wrapping modulo NM.
  - On a grant, `ptr <= winner + 1`, with wrap `NM-1 -> 0`.
- Slot choice: lowest index `i` with `F[i] = 1`, fixed priority.
- State machine:
  - IDLE: if `|V` and `|F`, register `EProjActvt <= 1<<slot`, `FireAck <= 1<<winner`, `ShooterIdx <= winner`, update `ptr`, and go to GRANT. Otherwise stay in IDLE with the pulse outputs at 0.
  - GRANT: clear `EProjActvt` and `FireAck`. If `COOLDOWN = 0`, go to IDLE. Otherwise load `cnt <= COOLDOWN-1` and go to COOL.
  - COOL: if `cnt = 0`, go to IDLE; otherwise `cnt <= cnt-1`. Requests arriving in COOL are not acked; they stay pending.
- Boundary conditions:
  - All slots busy: no grant, and `ptr` is unchanged.
  - Only one requester: it wins regardless of `ptr`.
  - A slot freed in the same frame that a request rises is usable in that frame, because `EProjEn` is sampled combinationally in IDLE.
  - A request that drops before its ack is simply never granted; there is no abort state.
  - A ship that dies in the frame it wins still receives the pulse, because `ShipAlive` is only sampled in IDLE.
- Reset, at any state including mid-COOL: `EProjActvt = 0`, `FireAck = 0`, `ShooterIdx = 0`, `ptr = 0`, `cnt = 0`, state IDLE, `Busy = 0`.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- A request valid before edge N while in IDLE gives `EProjActvt`/`FireAck` high after edge N and low after edge N+1.
- Grant-to-grant spacing is at least `COOLDOWN + 2` frames.
  - `COOLDOWN = 0`: grants at N, N+2, N+4, … under continuous requests.
- `Busy` goes high after edge N. It goes low after edge N+1 when `COOLDOWN = 0`, otherwise after edge N+1+COOLDOWN.
- Requesters must treat `FireAck` as the only handshake. They drop `FireReq` on or after the ack frame; a request still held in the next IDLE competes again.

## Configuration
- `EFIRE_SHOTCNT_EN`: when defined, adds output `ShotCount` [15:0].
  - It increments on every grant edge and saturates at 16'hFFFF.
  - Reset value is 0.
- When `EFIRE_SHOTCNT_EN` is undefined, the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset mid-COOL, with `COOLDOWN=8`, 3 frames into COOL: all outputs 0, `Busy=0`, `ptr=0`. The next request from ship 5 is granted 1 frame after the request is applied.
- Fairness, with `NM=16`, `COOLDOWN=0`, and `FireReq=ShipAlive=16'h8001` held: winners alternate 0, 15, 0, 15. Pulses appear every 2 frames.
- Slot allocation, with `EProjEn=4'b0101` and ship 3 requesting: `EProjActvt=4'b0010`, `FireAck=1<<3`, `ShooterIdx=3`.
- Full pool, with `EProjEn=4'b1111` and ship 2 requesting for 5 frames: no pulse and `ptr` unchanged. Set `EProjEn=4'b0111`: the pulse `EProjActvt=4'b1000` appears after the next edge.
- Dead-ship masking, with `FireReq=16'h0030` and `ShipAlive=16'h0020`: only ship 5 is ever acked.
- Cooldown, with `COOLDOWN=3` and continuous request from ship 1: grants exactly 5 frames apart. With `EFIRE_SHOTCNT_EN` defined, `ShotCount` equals 4 after 4 grants.
